conv_1d_param: RTL and testbench

Parametrised successor to the fixed-size 1-D convolution engine (128-sample input, 32-tap filter). For each job it loads N signed input samples x and M signed filter taps f over valid/ready streams, then emits the N-M+1 sliding dot products y[m] = sum over j=0..M-1 of x[m+j]*f[j], in order. Compared with the fixed-size block it adds three things:
- generic sizes;
- optional filter reuse across jobs, which skips the f reload;
- optional ReLU on the output.

It sits between the x/f stream sources and the y consumer in the project datapath.

---
 rtl/conv_1d_param.sv | 147 ++++++++++++++
 tb/tb_conv_1d_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1d_param.sv
// conv_1d_param: streaming 1-D convolution of N samples by M taps. Each output is
// one dot product issued through a read -> multiply -> accumulate pipeline every M+3 cycles.
module conv_1d_param #(
    parameter int N    = 128,
    parameter int M    = 32,
    parameter int T    = 8,
    parameter int RELU = 0,
    parameter int P    = 2*T + $clog2(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] s_data_in_x,
    input  logic                s_valid_x,
    output logic                s_ready_x,
    input  logic signed [T-1:0] s_data_in_f,
    input  logic                s_valid_f,
    output logic                s_ready_f,
    input  logic                cfg_reuse_f,
    output logic signed [P-1:0] m_data_out_y,
    output logic                m_valid_y,
    input  logic                m_ready_y
);
    localparam int XAW    = $clog2(N);
    localparam int FAW    = $clog2(M);
    localparam int XCW    = $clog2(N+1);
    localparam int FCW    = $clog2(M+1);
    localparam int KW     = $clog2(M+3);
    localparam int STAGES = 2;

    localparam logic [XCW-1:0] N_C    = XCW'(N);
    localparam logic [XCW-1:0] N_M1   = XCW'(N-1);
    localparam logic [FCW-1:0] M_C    = FCW'(M);
    localparam logic [FCW-1:0] M_M1   = FCW'(M-1);
    localparam logic [KW-1:0]  K_ISS  = KW'(M);
    localparam logic [KW-1:0]  K_LAST = KW'(M+2);
    localparam logic [XAW-1:0] M_LAST = XAW'(N-M);

    localparam logic [1:0] LOAD    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    logic [1:0]            state;
    logic [XCW-1:0]        x_cnt;
    logic [FCW-1:0]        f_cnt;
    logic                  f_loaded;
    logic [XAW-1:0]        m_idx;
    logic [KW-1:0]         k;
    logic signed [T-1:0]   x_mem [N];
    logic signed [T-1:0]   f_mem [M];
    logic signed [T-1:0]   rd_x, rd_f;
    logic signed [2*T-1:0] prod;
    logic signed [P-1:0]   prod_ext, acc, y_next;
    logic [STAGES-1:0]     vld_pipe, fst_pipe;

    logic x_fire, f_fire, x_done, f_done, load_done;
    logic issue, stall, out_load;
    logic [XAW-1:0] x_addr;
    logic [FAW-1:0] f_addr;

    assign s_ready_x = (state == LOAD) && (x_cnt < N_C);
    assign s_ready_f = (state == LOAD) && (f_cnt < M_C);
    assign x_fire    = s_valid_x && s_ready_x;
    assign f_fire    = s_valid_f && s_ready_f;

    // Leave LOAD on the very edge that stores the final sample/tap.
    assign x_done    = (x_cnt == N_C) || (x_fire && x_cnt == N_M1);
    assign f_done    = (f_cnt == M_C) || (f_fire && f_cnt == M_M1);
    assign load_done = (state == LOAD) && x_done && f_done;

    // k walks 0..M+2 per output: M read issues, then the pipeline tail.
    assign issue    = (state == COMPUTE) && (k < K_ISS);
    assign stall    = m_valid_y && !m_ready_y;
    assign out_load = (state == COMPUTE) && (k == K_LAST) && !stall;
    assign x_addr   = m_idx + XAW'(k);
    assign f_addr   = FAW'(k);

    assign prod_ext = {{(P-2*T){prod[2*T-1]}}, prod};
    assign y_next   = (RELU != 0 && acc[P-1]) ? '0 : acc;

    always_ff @(posedge clk) begin
        if (x_fire) x_mem[x_cnt[XAW-1:0]] <= s_data_in_x;
        if (f_fire) f_mem[f_cnt[FAW-1:0]] <= s_data_in_f;
        if (issue) begin
            rd_x <= x_mem[x_addr];
            rd_f <= f_mem[f_addr];
        end
        if (vld_pipe[0]) prod <= rd_x * rd_f;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            x_cnt        <= '0;
            f_cnt        <= '0;
            f_loaded     <= 1'b0;
            m_idx        <= '0;
            k            <= '0;
            vld_pipe     <= '0;
            fst_pipe     <= '0;
            acc          <= '0;
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], issue};
            fst_pipe <= {fst_pipe[0], issue && (k == '0)};
            if (vld_pipe[1]) acc <= fst_pipe[1] ? prod_ext : acc + prod_ext;

            if (out_load) begin
                m_valid_y    <= 1'b1;
                m_data_out_y <= y_next;
            end else if (m_ready_y) begin
                m_valid_y <= 1'b0;
            end

            case (state)
                LOAD: begin
                    if (x_fire) x_cnt <= x_cnt + 1'b1;
                    if (f_fire) f_cnt <= f_cnt + 1'b1;
                    if (load_done) begin
                        state    <= COMPUTE;
                        f_loaded <= 1'b1;
                        m_idx    <= '0;
                        k        <= '0;
                    end
                end
                COMPUTE: begin
                    // Only the hand-off step waits on a full output register.
                    if (k != K_LAST) begin
                        k <= k + 1'b1;
                    end else if (!stall) begin
                        k <= '0;
                        if (m_idx == M_LAST) state <= DRAIN;
                        else                 m_idx <= m_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_ready_y) begin
                        state <= LOAD;
                        x_cnt <= '0;
                        f_cnt <= (cfg_reuse_f && f_loaded) ? M_C : '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_1d_param.sv
// Directed bench for conv_1d_param: default, RELU=1 and small (N=8, M=3, T=4) instances.
module tb_conv_1d_param;
    localparam int N  = 128, M = 32, T = 8, P = 2*T + $clog2(M);
    localparam int N2 = 8, M2 = 3, T2 = 4, P2 = 2*T2 + $clog2(M2);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [T-1:0]  s_data_in_x, s_data_in_f;
    logic                 s_valid_x, s_ready_x, s_valid_f, s_ready_f, cfg_reuse_f;
    logic signed [P-1:0]  m_data_out_y, r_data;
    logic                 m_valid_y, m_ready_y, r_valid, r_ready_x, r_ready_f;
    logic signed [T2-1:0] s2_dx, s2_df;
    logic                 s2_vx, s2_rx, s2_vf, s2_rf, s2_reuse, s2_vy, s2_ry;
    logic signed [P2-1:0] s2_y;

    conv_1d_param #(.N(N), .M(M), .T(T), .RELU(0)) u_dut (
        .clk(clk), .reset(reset),
        .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
        .cfg_reuse_f(cfg_reuse_f),
        .m_data_out_y(m_data_out_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y));

    conv_1d_param #(.N(N), .M(M), .T(T), .RELU(1)) u_relu (
        .clk(clk), .reset(reset),
        .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(r_ready_x),
        .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(r_ready_f),
        .cfg_reuse_f(cfg_reuse_f),
        .m_data_out_y(r_data), .m_valid_y(r_valid), .m_ready_y(m_ready_y));

    conv_1d_param #(.N(N2), .M(M2), .T(T2)) u_small (
        .clk(clk), .reset(reset),
        .s_data_in_x(s2_dx), .s_valid_x(s2_vx), .s_ready_x(s2_rx),
        .s_data_in_f(s2_df), .s_valid_f(s2_vf), .s_ready_f(s2_rf),
        .cfg_reuse_f(s2_reuse),
        .m_data_out_y(s2_y), .m_valid_y(s2_vy), .m_ready_y(s2_ry));

    // x[i] = x0 + xi*i, f[j] = f0 + fi*j; expected y[m] = y0 + step*m.
    typedef struct {
        int x0, xi, f0, fi;
        bit send_f, reuse, rnd;
        int y0, step;
    } job_t;

    job_t jobs[5];
    int   errs = 0, checks = 0;
    int   last_x, last_f;
    bit   rf_bad;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_x(input job_t j);
        int i = 0, guard = 0;
        bit fire;
        last_x = -1;
        while (i < N && guard < 5000) begin
            s_valid_x   = j.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data_in_x = s_valid_x ? T'(j.x0 + j.xi*i) : T'($urandom);
            @(negedge clk);
            fire = s_valid_x && s_ready_x;
            if (!j.send_f && s_ready_f) rf_bad = 1'b1;
            @(posedge clk); #1;
            guard++;
            if (fire) begin i++; last_x = cyc; end
        end
        s_valid_x = 1'b0;
        chk("x_loaded", i, N);
    endtask

    task automatic send_f(input job_t j);
        int i = 0, guard = 0;
        bit fire;
        last_f = -1;
        if (j.send_f) begin
            while (i < M && guard < 5000) begin
                s_valid_f   = j.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_data_in_f = s_valid_f ? T'(j.f0 + j.fi*i) : T'($urandom);
                @(negedge clk);
                fire = s_valid_f && s_ready_f;
                @(posedge clk); #1;
                guard++;
                if (fire) begin i++; last_f = cyc; end
            end
            s_valid_f = 1'b0;
            chk("f_loaded", i, M);
        end
    endtask

    task automatic consume(input job_t j);
        int k = 0, guard = 0, first_c = -1, second_c = -1, load_c;
        bit held = 1'b0;
        logic signed [P-1:0] hd = '0;
        longint e;
        while (k < N-M+1 && guard < 20000) begin
            m_ready_y = j.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (held) begin
                chk("hold_valid", m_valid_y, 1);
                chk("hold_data", m_data_out_y, hd);
            end
            held = m_valid_y && !m_ready_y;
            hd   = m_data_out_y;
            if (m_valid_y && m_ready_y) begin
                e = j.y0 + j.step*k;
                chk("y", m_data_out_y, e);
                chk("relu_valid", r_valid, 1);
                chk("relu_y", r_data, (e < 0) ? 0 : e);
                if (k == 0) first_c = cyc;
                if (k == 1) second_c = cyc;
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        chk("n_outputs", k, N-M+1);
        if (!j.rnd) begin
            load_c = (last_x > last_f) ? last_x : last_f;
            chk("first_latency", first_c - load_c, M+3);
            chk("out_spacing", second_c - first_c, M+3);
        end
    endtask

    task automatic run_job(input job_t j);
        cfg_reuse_f = j.reuse;
        rf_bad = 1'b0;
        fork
            send_x(j);
            send_f(j);
            consume(j);
        join
        if (!j.send_f) chk("ready_f_reuse", rf_bad, 0);
    endtask

    int small_exp[6];
    int idle_bad, guard, k, nx, nf, load_c;

    initial begin
        jobs[0] = '{x0:-128, xi:1, f0:-64,  fi:1, send_f:1, reuse:0, rnd:0, y0:177328, step:-1552};
        jobs[1] = '{x0:0,    xi:1, f0:-32,  fi:1, send_f:1, reuse:0, rnd:1, y0:-5456,  step:-528};
        jobs[2] = '{x0:-128, xi:1, f0:-64,  fi:1, send_f:1, reuse:1, rnd:1, y0:177328, step:-1552};
        jobs[3] = '{x0:0,    xi:1, f0:0,    fi:0, send_f:0, reuse:0, rnd:1, y0:-21328, step:-1552};
        jobs[4] = '{x0:-128, xi:0, f0:-128, fi:0, send_f:1, reuse:0, rnd:1, y0:524288, step:0};
        // x = 1..8 does not fit 4-bit signed; -1..-8 against f = -1 gives the same sums.
        small_exp = '{6, 9, 12, 15, 18, 21};

        reset = 1'b1;
        s_valid_x = 0; s_valid_f = 0; s_data_in_x = '0; s_data_in_f = '0;
        cfg_reuse_f = 0; m_ready_y = 0;
        s2_vx = 0; s2_vf = 0; s2_dx = '0; s2_df = '0; s2_reuse = 0; s2_ry = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_x", s_ready_x, 1);
        chk("rst_ready_f", s_ready_f, 1);
        chk("rst_valid", m_valid_y, 0);
        chk("rst_data", m_data_out_y, 0);
        chk("rst_small_valid", s2_vy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        m_ready_y = 1'b1;
        idle_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (m_valid_y || r_valid) idle_bad++;
        end
        chk("idle_no_valid", idle_bad, 0);

        // Reset while y[0] is held and y[1] is in flight, with reuse requested.
        @(posedge clk); #1;
        cfg_reuse_f = 1'b1;
        m_ready_y   = 1'b0;
        fork
            send_x(jobs[0]);
            send_f(jobs[0]);
        join
        guard = 0;
        while (!m_valid_y && guard < 200) begin @(negedge clk); guard++; end
        repeat (5) @(negedge clk);
        chk("pre_reset_valid", m_valid_y, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", m_valid_y, 0);
        chk("mid_rst_ready_x", s_ready_x, 1);
        chk("mid_rst_ready_f", s_ready_f, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_job(jobs[0]);

        // Small instance: x and f stream concurrently, consumer always ready.
        nx = 0; nf = 0;
        for (int i = 0; i < N2; i++) begin
            s2_vx = 1'b1;
            s2_dx = T2'(-(i + 1));
            s2_vf = (i < M2);
            s2_df = T2'(-1);
            @(negedge clk);
            if (s2_vx && s2_rx) nx++;
            if (s2_vf && s2_rf) nf++;
            @(posedge clk); #1;
        end
        load_c = cyc;
        s2_vx = 1'b0; s2_vf = 1'b0; s2_ry = 1'b1;
        chk("small_x_count", nx, N2);
        chk("small_f_count", nf, M2);
        k = 0; guard = 0;
        while (k < N2-M2+1 && guard < 200) begin
            @(negedge clk);
            if (k == 0) chk("small_ready_x_busy", s2_rx, 0);
            if (s2_vy) begin
                if (k == 0) chk("small_latency", cyc - load_c, M2+3);
                chk("small_y", s2_y, small_exp[k]);
                k++;
            end
            guard++;
        end
        chk("small_n_outputs", k, N2-M2+1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
